// File: rtl/traffic_pkg.sv
// Shared lamp codes, FSM state encoding and lamp-decode helpers for the
// highway / farm-road intersection sequencer.
package traffic_pkg;

    localparam logic [1:0] LAMP_OFF    = 2'b00;
    localparam logic [1:0] LAMP_RED    = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_GREEN  = 2'b11;

    typedef enum logic [2:0] {
        HG    = 3'd0,
        HY    = 3'd1,
        FG    = 3'd2,
        FY    = 3'd3,
        FAULT = 3'd4
    } state_t;

    // Highway lamp shown in a normal (non-fault) state.
    function automatic logic [1:0] hw_lamp(input state_t s);
        case (s)
            HG:      return LAMP_GREEN;
            HY:      return LAMP_YELLOW;
            FG, FY:  return LAMP_RED;
            default: return LAMP_OFF;
        endcase
    endfunction

    // Farm-road lamp shown in a normal (non-fault) state.
    function automatic logic [1:0] fr_lamp(input state_t s);
        case (s)
            HG, HY:  return LAMP_RED;
            FG:      return LAMP_GREEN;
            FY:      return LAMP_YELLOW;
            default: return LAMP_OFF;
        endcase
    endfunction

    // Green phases use the long delay, yellow phases the short one.
    function automatic logic uses_long_timer(input state_t s);
        return (s == HG) || (s == FG);
    endfunction

endpackage

// File: rtl/tl_watchdog.sv
// Counts cycles spent waiting on the timing counter; flags expiry once the
// count reaches WDOG_CYCLES-1 so the sequencer can fall into FAULT.
module tl_watchdog #(
    parameter int WDOG_CYCLES = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] count_reg;
    logic [WDOG_W-1:0] count_next;

    // Restart on every timer start; otherwise count up while waiting and
    // hold at the last value so the counter can never wrap.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != WDOG_LAST)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = enable && (count_reg == WDOG_LAST);

endmodule

// File: rtl/traffic_light_fsm.sv
// Highway-priority intersection sequencer. Starts the external long/short
// timer on every state entry, advances on its done pulse, and drops into a
// latched flashing-yellow FAULT mode if the timer stops answering.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int WDOG_CYCLES = 300,
    parameter int BLINK_HALF  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_sensor,
    input  logic       timer_done,
    output logic       start_long,
    output logic       start_short,
    output logic [1:0] hw_light,
    output logic [1:0] fr_light,
    output logic       fault
);

    localparam int                 BLINK_W    = $clog2(BLINK_HALF + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    state_t             state_reg,       state_next;
    logic               waiting_reg,     waiting_next;
    logic               min_done_reg,    min_done_next;
    logic               boot_reg,        boot_next;
    logic               start_long_reg,  start_long_next;
    logic               start_short_reg, start_short_next;
    logic [1:0]         hw_reg,          hw_next;
    logic [1:0]         fr_reg,          fr_next;
    logic               fault_reg,       fault_next;
    logic [BLINK_W-1:0] blink_cnt_reg,   blink_cnt_next;
    logic               blink_on_reg,    blink_on_next;

    logic start_req;
    logic done_ok;
    logic wdog_expired;

    tl_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_req),
        .enable  (waiting_reg),
        .expired (wdog_expired)
    );

    // Next-state, timer-start and lamp decode. Outputs are computed from the
    // next state so the registered lamps and start pulse line up with entry.
    always_comb begin
        state_next       = state_reg;
        waiting_next     = waiting_reg;
        min_done_next    = min_done_reg;
        boot_next        = boot_reg;
        start_long_next  = 1'b0;
        start_short_next = 1'b0;
        hw_next          = hw_reg;
        fr_next          = fr_reg;
        fault_next       = fault_reg;
        blink_cnt_next   = blink_cnt_reg;
        blink_on_next    = blink_on_reg;
        start_req        = 1'b0;
        // Done pulses only count while a timer is actually outstanding.
        done_ok          = timer_done && waiting_reg;

        if ((state_reg != FAULT) && wdog_expired && !timer_done) begin
            state_next     = FAULT;
            waiting_next   = 1'b0;
            fault_next     = 1'b1;
            blink_cnt_next = '0;
            blink_on_next  = 1'b1;
            hw_next        = LAMP_YELLOW;
            fr_next        = LAMP_YELLOW;
        end else begin
            case (state_reg)
                HG: begin
                    if (boot_reg) begin
                        // First cycle out of reset: kick off the highway green.
                        boot_next = 1'b0;
                        start_req = 1'b1;
                    end else if (done_ok) begin
                        waiting_next = 1'b0;
                        if (car_sensor) begin
                            state_next = HY;
                        end else begin
                            min_done_next = 1'b1;
                        end
                    end else if (min_done_reg && car_sensor) begin
                        state_next = HY;
                    end
                end
                HY: begin
                    if (done_ok) begin
                        waiting_next = 1'b0;
                        state_next   = FG;
                    end
                end
                FG: begin
                    // The counter cannot be cancelled, so the car is ignored here.
                    if (done_ok) begin
                        waiting_next = 1'b0;
                        state_next   = FY;
                    end
                end
                FY: begin
                    if (done_ok) begin
                        waiting_next  = 1'b0;
                        min_done_next = 1'b0;
                        state_next    = HG;
                    end
                end
                FAULT: begin
                    // Both roads blink yellow/off together; only reset leaves.
                    if (blink_cnt_reg == BLINK_LAST) begin
                        blink_cnt_next = '0;
                        blink_on_next  = !blink_on_reg;
                        hw_next        = blink_on_reg ? LAMP_OFF : LAMP_YELLOW;
                        fr_next        = blink_on_reg ? LAMP_OFF : LAMP_YELLOW;
                    end else begin
                        blink_cnt_next = blink_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = FAULT;
                end
            endcase

            if ((state_next != state_reg) && (state_next != FAULT)) begin
                start_req = 1'b1;
            end

            if (state_next != FAULT) begin
                hw_next = hw_lamp(state_next);
                fr_next = fr_lamp(state_next);
            end
        end

        if (start_req) begin
            waiting_next = 1'b1;
            if (uses_long_timer(state_next)) begin
                start_long_next = 1'b1;
            end else begin
                start_short_next = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= HG;
            waiting_reg     <= 1'b0;
            min_done_reg    <= 1'b0;
            boot_reg        <= 1'b1;
            start_long_reg  <= 1'b0;
            start_short_reg <= 1'b0;
            hw_reg          <= LAMP_GREEN;
            fr_reg          <= LAMP_RED;
            fault_reg       <= 1'b0;
            blink_cnt_reg   <= '0;
            blink_on_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            waiting_reg     <= waiting_next;
            min_done_reg    <= min_done_next;
            boot_reg        <= boot_next;
            start_long_reg  <= start_long_next;
            start_short_reg <= start_short_next;
            hw_reg          <= hw_next;
            fr_reg          <= fr_next;
            fault_reg       <= fault_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_on_reg    <= blink_on_next;
        end
    end

    assign start_long  = start_long_reg;
    assign start_short = start_short_reg;
    assign hw_light    = hw_reg;
    assign fr_light    = fr_reg;
    assign fault       = fault_reg;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with a behavioural timing counter.
module tb_traffic_light_fsm;
    import traffic_pkg::*;

    localparam int N_LONG  = 250;
    localparam int N_SHORT = 40;
    localparam int WDOG    = 300;
    localparam int BLINK   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_sensor = 1'b0;
    logic       timer_done = 1'b0;
    logic       start_long;
    logic       start_short;
    logic [1:0] hw_light;
    logic [1:0] fr_light;
    logic       fault;

    always #5 clk = ~clk;

    traffic_light_fsm #(
        .WDOG_CYCLES (WDOG),
        .BLINK_HALF  (BLINK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .car_sensor  (car_sensor),
        .timer_done  (timer_done),
        .start_long  (start_long),
        .start_short (start_short),
        .hw_light    (hw_light),
        .fr_light    (fr_light),
        .fault       (fault)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t_boot      = 0;

    // Timer model state: countdown, mute (never answers), stray-pulse requests.
    int tmr_cnt     = -1;
    bit tmr_mute    = 1'b0;
    int inject_req  = 0;
    int inject_seen = 0;
    int n_sl        = 0;
    int n_ss        = 0;
    int n_both      = 0;

    // Behavioural timing counter: done is sampled N edges after the start pulse.
    always @(negedge clk) begin
        timer_done = 1'b0;
        if (inject_req != inject_seen) begin
            timer_done  = 1'b1;
            inject_seen = inject_req;
        end
        if (tmr_cnt > 0) begin
            tmr_cnt = tmr_cnt - 1;
            if (tmr_cnt == 0) begin
                timer_done = 1'b1;
                tmr_cnt    = -1;
            end
        end
        if (start_long)                n_sl   = n_sl + 1;
        if (start_short)               n_ss   = n_ss + 1;
        if (start_long && start_short) n_both = n_both + 1;
        if (!tmr_mute && start_long)       tmr_cnt = N_LONG - 1;
        else if (!tmr_mute && start_short) tmr_cnt = N_SHORT - 1;
    end

    typedef struct {
        logic       car;
        logic [1:0] hw;
        logic [1:0] fr;
        logic       sl;
        logic       ss;
        int         elapsed;
    } vec_t;

    vec_t tbl [5];

    task automatic step();
        @(negedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Step until any lamp or the fault flag changes, bounded by max_cycles.
    task automatic wait_change(input string name, input int max_cycles, output int elapsed);
        logic [1:0] h0;
        logic [1:0] f0;
        logic       fl0;
        h0 = hw_light;
        f0 = fr_light;
        fl0 = fault;
        elapsed = 0;
        do begin
            step();
            elapsed = elapsed + 1;
        end while ((hw_light == h0) && (fr_light == f0) && (fault == fl0) && (elapsed < max_cycles));
        if ((hw_light == h0) && (fr_light == f0) && (fault == fl0)) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL %s: no transition within %0d cycles", name, max_cycles);
        end
    endtask

    // Assert reset for two edges, check reset lamps, release and check boot start.
    task automatic apply_reset(input string name);
        int base;
        rst = 1'b1;
        step();
        check({name, "_hw"},    int'(hw_light),    int'(LAMP_GREEN));
        check({name, "_fr"},    int'(fr_light),    int'(LAMP_RED));
        check({name, "_fault"}, int'(fault),       0);
        check({name, "_sl"},    int'(start_long),  0);
        check({name, "_ss"},    int'(start_short), 0);
        step();
        rst = 1'b0;
        base = n_sl;
        step();
        t_boot = cyc;
        check({name, "_boot_sl"}, int'(start_long), 1);
        step();
        check({name, "_boot_sl_off"}, int'(start_long), 0);
        check({name, "_boot_sl_count"}, n_sl - base, 1);
    endtask

    initial begin
        int e;
        int bad;
        int base_l;
        int base_s;
        int t_fg;
        logic [1:0] exp_lamp;

        tbl[0] = '{car: 1'b1, hw: LAMP_YELLOW, fr: LAMP_RED,    sl: 1'b0, ss: 1'b1, elapsed: 1};
        tbl[1] = '{car: 1'b1, hw: LAMP_RED,    fr: LAMP_GREEN,  sl: 1'b1, ss: 1'b0, elapsed: N_SHORT};
        tbl[2] = '{car: 1'b1, hw: LAMP_RED,    fr: LAMP_YELLOW, sl: 1'b0, ss: 1'b1, elapsed: N_LONG};
        tbl[3] = '{car: 1'b1, hw: LAMP_GREEN,  fr: LAMP_RED,    sl: 1'b1, ss: 0,    elapsed: N_SHORT};
        tbl[4] = '{car: 1'b1, hw: LAMP_YELLOW, fr: LAMP_RED,    sl: 1'b0, ss: 1'b1, elapsed: N_LONG};

        // Reset and an idle highway: one long start, GREEN/RED for 1000 cycles.
        base_l = n_sl;
        base_s = n_ss;
        apply_reset("rst_init");
        bad = 0;
        while (cyc < t_boot + 1000) begin
            if ((hw_light != LAMP_GREEN) || (fr_light != LAMP_RED)) bad = bad + 1;
            step();
        end
        check("idle_lamp_errors", bad, 0);
        check("idle_start_long_count", n_sl - base_l, 1);
        check("idle_start_short_count", n_ss - base_s, 0);

        // Stray done in HG after min_done: ignored.
        base_l = n_sl;
        base_s = n_ss;
        inject_req = inject_req + 1;
        repeat (5) step();
        check("hg_stray_hw", int'(hw_light), int'(LAMP_GREEN));
        check("hg_stray_starts", (n_sl - base_l) + (n_ss - base_s), 0);

        // Late car then a full cycle; last row shows min_done cleared in new HG.
        for (int i = 0; i < 5; i++) begin
            base_l = n_sl;
            car_sensor = tbl[i].car;
            wait_change($sformatf("row%0d_wait", i), 400, e);
            check($sformatf("row%0d_hw", i), int'(hw_light), int'(tbl[i].hw));
            check($sformatf("row%0d_fr", i), int'(fr_light), int'(tbl[i].fr));
            check($sformatf("row%0d_sl", i), int'(start_long), int'(tbl[i].sl));
            check($sformatf("row%0d_ss", i), int'(start_short), int'(tbl[i].ss));
            check($sformatf("row%0d_elapsed", i), e, tbl[i].elapsed);
            check($sformatf("row%0d_sl_count", i), n_sl - base_l, int'(tbl[i].sl));
        end
        car_sensor = 1'b0;

        // Car arrives during the minimum green: HY on the edge after done.
        apply_reset("rst_car50");
        while (cyc < t_boot + 49) step();
        car_sensor = 1'b1;
        base_s = n_ss;
        wait_change("car50_wait", 400, e);
        check("car50_hw", int'(hw_light), int'(LAMP_YELLOW));
        check("car50_latency", cyc - t_boot, N_LONG);
        check("car50_ss", int'(start_short), 1);
        wait_change("car50_fg_wait", 100, e);
        check("car50_fg_fr", int'(fr_light), int'(LAMP_GREEN));
        check("car50_ss_once", n_ss - base_s, 1);

        // Stray done during FG is accepted: exactly one transition to FY.
        repeat (10) step();
        inject_req = inject_req + 1;
        wait_change("fg_stray_wait", 5, e);
        check("fg_stray_fr", int'(fr_light), int'(LAMP_YELLOW));
        check("fg_stray_ss", int'(start_short), 1);
        base_l = n_sl;
        bad = 0;
        repeat (30) begin
            step();
            if ((hw_light != LAMP_RED) || (fr_light != LAMP_YELLOW)) bad = bad + 1;
        end
        check("fg_stray_single_transition", bad, 0);
        check("fg_stray_no_long", n_sl - base_l, 0);

        // Reset in the middle of FY.
        apply_reset("rst_mid_fy");

        // Timer never answers in FG: watchdog FAULT, then blink.
        wait_change("wd_hy_wait", 400, e);
        check("wd_hy_hw", int'(hw_light), int'(LAMP_YELLOW));
        tmr_mute = 1'b1;
        wait_change("wd_fg_wait", 100, e);
        check("wd_fg_sl", int'(start_long), 1);
        t_fg = cyc;
        wait_change("wd_fault_wait", 400, e);
        check("wd_fault_flag", int'(fault), 1);
        check("wd_latency", cyc - t_fg, WDOG);
        base_l = n_sl;
        base_s = n_ss;
        for (int i = 0; i < 6 * BLINK; i++) begin
            exp_lamp = (((i / BLINK) % 2) == 0) ? LAMP_YELLOW : LAMP_OFF;
            check($sformatf("blink%0d_hw", i), int'(hw_light), int'(exp_lamp));
            check($sformatf("blink%0d_fr", i), int'(fr_light), int'(exp_lamp));
            if (i == 12) inject_req = inject_req + 1;
            step();
        end
        check("fault_held", int'(fault), 1);
        check("fault_no_starts", (n_sl - base_l) + (n_ss - base_s), 0);

        // Reset out of FAULT.
        tmr_mute = 1'b0;
        car_sensor = 1'b0;
        apply_reset("rst_mid_fault");
        check("never_both_starts", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
